// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard unit: register-index width,
// forward-select encodings and the in-flight destination entry.
package mips_pkg;

    localparam int DEF_REG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [DEF_REG_W-1:0] dst;
        logic                 load;
    } entry_t;

    // Match bit 0 is EX (youngest), bit 2 is WB (oldest); youngest producer wins.
    function automatic logic [1:0] fwd_pick(input logic [2:0] match);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (match[0]) begin
            sel = FWD_EX;
        end else if (match[1]) begin
            sel = FWD_MEM;
        end else if (match[2]) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one ID source register against the EX, MEM and WB entries.
// Register 0 and unused sources never match.
module hazard_cmp
    import mips_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    input  entry_t           ex_i,
    input  entry_t           mem_i,
    input  entry_t           wb_i,
    output logic [2:0]       match_o
);

    logic live;

    assign live       = use_i && (src_i != '0);
    assign match_o[0] = live && ex_i.valid  && (ex_i.dst  == src_i);
    assign match_o[1] = live && mem_i.valid && (mem_i.dst == src_i);
    assign match_o[2] = live && wb_i.valid  && (wb_i.dst  == src_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks EX/MEM/WB destinations, raises load-use stalls
// and selects operand forwarding. HAZARD_FWD_EN enables forwarding; without it
// every RAW dependency on an in-flight writer stalls and forwarding is off.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_we_rd,
    input  logic             i_id_we_rt,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_id_load,
    input  logic             i_flush,
    input  logic             i_hold,
    output logic             o_stall,
    output logic [1:0]       o_fwd_rs,
    output logic [1:0]       o_fwd_rt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    entry_t           ex_q, mem_q, wb_q;
    entry_t           ex_d, mem_d, wb_d;
    entry_t           id_entry;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       match_rs, match_rt;
    logic             hazard;
    logic             unused_wb_load;

    // rd takes precedence when the decoder asserts both write enables.
    always_comb begin
        id_entry = '0;
        if (i_id_we_rd) begin
            id_entry.dst = i_id_rd;
        end else if (i_id_we_rt) begin
            id_entry.dst = i_id_rt;
        end
        id_entry.valid = (i_id_we_rd || i_id_we_rt) && (id_entry.dst != '0);
        id_entry.load  = i_id_load;
    end

    hazard_cmp #(.REG_W(REG_W)) u_cmp_rs (
        .src_i   (i_id_rs),
        .use_i   (i_id_use_rs),
        .ex_i    (ex_q),
        .mem_i   (mem_q),
        .wb_i    (wb_q),
        .match_o (match_rs)
    );

    hazard_cmp #(.REG_W(REG_W)) u_cmp_rt (
        .src_i   (i_id_rt),
        .use_i   (i_id_use_rt),
        .ex_i    (ex_q),
        .mem_i   (mem_q),
        .wb_i    (wb_q),
        .match_o (match_rt)
    );

`ifdef HAZARD_FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = (match_rs[0] || match_rt[0]) && ex_q.load;
`else
    assign hazard = (|match_rs) || (|match_rt);
`endif

    // A taken branch/jump squashes the ID instruction, so it cannot stall.
    assign o_stall = i_id_valid && !i_flush && hazard;

    always_comb begin
        o_fwd_rs = FWD_NONE;
        o_fwd_rt = FWD_NONE;
`ifdef HAZARD_FWD_EN
        if (!o_stall) begin
            o_fwd_rs = fwd_pick(match_rs);
            o_fwd_rt = fwd_pick(match_rt);
        end
`endif
    end

    always_comb begin
        ex_d  = id_entry;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (o_stall || i_flush || !i_id_valid) begin
            ex_d = '0;
        end
        cnt_d = cnt_q;
        if (o_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (!i_hold) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_stall_cnt    = cnt_q;
    assign unused_wb_load = wb_q.load;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; a behavioural pipeline model predicts
// outputs per cycle, directed cases cover load-use, flush, hold, reset, saturation.
module tb_hazard_ctrl;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int OW = 5 + CNT_W;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       use_rs;
        logic       use_rt;
        logic       we_rd;
        logic       we_rt;
        logic       load;
    } id_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs = '0, id_rt = '0, id_rd = '0;
    logic             id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic             id_we_rd = 1'b0, id_we_rt = 1'b0;
    logic             id_load = 1'b0;
    logic             flush = 1'b0, hold = 1'b0;
    logic             stall;
    logic [1:0]       fwd_rs, fwd_rt;
    logic [CNT_W-1:0] stall_cnt;

    logic [OW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    logic             m_v[3]   = '{1'b0, 1'b0, 1'b0};
    logic [4:0]       m_dst[3] = '{5'd0, 5'd0, 5'd0};
    logic             m_ld[3]  = '{1'b0, 1'b0, 1'b0};
    logic [CNT_W-1:0] m_cnt    = '0;
    logic [CNT_W-1:0] cnt_base;

    hazard_ctrl #(.REG_W(5), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_id_valid  (id_valid),
        .i_id_rs     (id_rs),
        .i_id_rt     (id_rt),
        .i_id_use_rs (id_use_rs),
        .i_id_use_rt (id_use_rt),
        .i_id_we_rd  (id_we_rd),
        .i_id_we_rt  (id_we_rt),
        .i_id_rd     (id_rd),
        .i_id_load   (id_load),
        .i_flush     (flush),
        .i_hold      (hold),
        .o_stall     (stall),
        .o_fwd_rs    (fwd_rs),
        .o_fwd_rt    (fwd_rt),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] youngest(input logic [2:0] hit);
        for (int k = 0; k < 3; k++) begin
            if (hit[k]) return 2'(k + 1);
        end
        return 2'b00;
    endfunction

    function automatic void model_eval(output logic st, output logic [1:0] frs, output logic [1:0] frt);
        logic [2:0] hrs, hrt;
        for (int k = 0; k < 3; k++) begin
            hrs[k] = id_use_rs && (id_rs != 0) && m_v[k] && (m_dst[k] == id_rs);
            hrt[k] = id_use_rt && (id_rt != 0) && m_v[k] && (m_dst[k] == id_rt);
        end
`ifdef HAZARD_FWD_EN
        st  = id_valid && !flush && (hrs[0] || hrt[0]) && m_ld[0];
        frs = st ? 2'b00 : youngest(hrs);
        frt = st ? 2'b00 : youngest(hrt);
`else
        st  = id_valid && !flush && ((hrs != 0) || (hrt != 0));
        frs = 2'b00;
        frt = 2'b00;
`endif
    endfunction

    always @(posedge clk) begin
        logic       st;
        logic [1:0] a, b;
        logic [4:0] d;
        model_eval(st, a, b);
        if (rst) begin
            for (int k = 0; k < 3; k++) m_v[k] = 1'b0;
            m_cnt = '0;
        end else if (!hold) begin
            for (int k = 2; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_dst[k] = m_dst[k-1]; m_ld[k] = m_ld[k-1];
            end
            d        = id_we_rd ? id_rd : (id_we_rt ? id_rt : 5'd0);
            m_dst[0] = d;
            m_ld[0]  = id_load;
            m_v[0]   = !(st || flush || !id_valid) && (id_we_rd || id_we_rt) && (d != 0);
            if (st && (m_cnt != CNT_MAX)) m_cnt = m_cnt + 1'b1;
        end
    end

    function automatic id_t nop();
        id_t r = '0;
        return r;
    endfunction

    function automatic id_t r_type(input int s, input int t, input int d);
        id_t r = '0;
        r.valid = 1'b1; r.rs = 5'(s); r.rt = 5'(t); r.rd = 5'(d);
        r.use_rs = 1'b1; r.use_rt = 1'b1; r.we_rd = 1'b1;
        return r;
    endfunction

    function automatic id_t i_type(input int s, input int d);
        id_t r = '0;
        r.valid = 1'b1; r.rs = 5'(s); r.rt = 5'(d);
        r.use_rs = 1'b1; r.we_rt = 1'b1;
        return r;
    endfunction

    function automatic id_t lw(input int s, input int d);
        id_t r = i_type(s, d);
        r.load = 1'b1;
        return r;
    endfunction

    task automatic score(input string tag);
        logic             e_st;
        logic [1:0]       e_rs, e_rt;
        logic [CNT_W-1:0] e_cnt;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            {e_st, e_rs, e_rt, e_cnt} = exp_q.pop_front();
            check({tag, ".stall"}, 32'(stall), 32'(e_st));
            check({tag, ".fwd_rs"}, 32'(fwd_rs), 32'(e_rs));
            check({tag, ".fwd_rt"}, 32'(fwd_rt), 32'(e_rt));
            check({tag, ".cnt"}, 32'(stall_cnt), 32'(e_cnt));
        end
    endtask

    // Drive one cycle at the falling edge, predict, then compare before the rising edge.
    task automatic cyc(input string tag, input id_t id, input logic fl, input logic hd, input logic r);
        logic       st;
        logic [1:0] a, b;
        @(negedge clk);
        id_valid = id.valid; id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
        id_use_rs = id.use_rs; id_use_rt = id.use_rt;
        id_we_rd = id.we_rd; id_we_rt = id.we_rt; id_load = id.load;
        flush = fl; hold = hd; rst = r;
        model_eval(st, a, b);
        exp_q.push_back({st, a, b, m_cnt});
        #2;
        score(tag);
    endtask

    task automatic drain(input int n);
        repeat (n) cyc("drain", nop(), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);

        cyc("reset", nop(), 1'b0, 1'b0, 1'b0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd_rs", 32'(fwd_rs), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);

        // Load-use on rs.
        drain(3);
        cyc("lw8", lw(29, 8), 1'b0, 1'b0, 1'b0);
        cyc("use8", r_type(8, 9, 10), 1'b0, 1'b0, 1'b0);
        check("ldu_stall", 32'(stall), 32'd1);
        check("ldu_fwd_gated", 32'(fwd_rs), 32'd0);
        cyc("use8b", r_type(8, 9, 10), 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_FWD_EN
        check("ldu_fwd_mem", 32'(fwd_rs), 32'd2);
        check("ldu_release", 32'(stall), 32'd0);
`else
        check("ldu_stall_mem", 32'(stall), 32'd1);
`endif
        cyc("use8c", r_type(8, 9, 10), 1'b0, 1'b0, 1'b0);
        cyc("use8d", r_type(8, 9, 10), 1'b0, 1'b0, 1'b0);

        // Two writers of $5; the younger (EX) must win.
        drain(3);
        cyc("sub5", r_type(1, 2, 5), 1'b0, 1'b0, 1'b0);
        cyc("add5", r_type(1, 2, 5), 1'b0, 1'b0, 1'b0);
        cyc("rd5", r_type(6, 5, 7), 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_FWD_EN
        check("young_fwd_rt", 32'(fwd_rt), 32'd1);
        check("young_stall", 32'(stall), 32'd0);
`else
        check("nofwd_stall_ex", 32'(stall), 32'd1);
        check("nofwd_fwd_rt", 32'(fwd_rt), 32'd0);
`endif

        // Writes to $0 never create a dependency.
        drain(3);
        cyc("w0", r_type(1, 2, 0), 1'b0, 1'b0, 1'b0);
        cyc("r0", i_type(0, 6), 1'b0, 1'b0, 1'b0);
        check("zero_fwd", 32'(fwd_rs), 32'd0);
        check("zero_stall", 32'(stall), 32'd0);

        // Flush beats a simultaneous load-use stall and bubbles EX.
        drain(3);
        cyc("lw11", lw(29, 11), 1'b0, 1'b0, 1'b0);
        cyc("flush", lw(11, 12), 1'b1, 1'b0, 1'b0);
        check("flush_stall", 32'(stall), 32'd0);
        cyc("post_flush", i_type(12, 13), 1'b0, 1'b0, 1'b0);
        check("flush_bubble_stall", 32'(stall), 32'd0);
        check("flush_bubble_fwd", 32'(fwd_rs), 32'd0);

        // Hold freezes entries and counter during a load-use stall.
        drain(3);
        cyc("lw13", lw(29, 13), 1'b0, 1'b0, 1'b0);
        cnt_base = m_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc("hold", r_type(13, 1, 2), 1'b0, 1'b1, 1'b0);
            check("hold_stall", 32'(stall), 32'd1);
            check("hold_cnt", 32'(stall_cnt), 32'(cnt_base));
        end
        cyc("release", r_type(13, 1, 2), 1'b0, 1'b0, 1'b0);
        check("release_stall", 32'(stall), 32'd1);
        cyc("post_release", nop(), 1'b0, 1'b0, 1'b0);
        check("release_cnt", 32'(stall_cnt), 32'(cnt_base + 1'b1));

        // Reset in the middle of a stall.
        drain(3);
        cyc("lw14", lw(29, 14), 1'b0, 1'b0, 1'b0);
        cyc("pre_rst", r_type(14, 1, 2), 1'b0, 1'b0, 1'b0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        cyc("rst_mid", r_type(14, 1, 2), 1'b0, 1'b1, 1'b1);
        cyc("post_rst", r_type(14, 1, 2), 1'b0, 1'b0, 1'b0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_cnt", 32'(stall_cnt), 32'd0);

        // Dependency on a WB-stage ALU writer.
        drain(3);
        cyc("add3", r_type(1, 2, 3), 1'b0, 1'b0, 1'b0);
        drain(2);
        cyc("wb3", i_type(3, 4), 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_FWD_EN
        check("wb_fwd_rs", 32'(fwd_rs), 32'd3);
        check("wb_stall", 32'(stall), 32'd0);
`else
        check("wb_stall", 32'(stall), 32'd1);
        check("wb_fwd_rs", 32'(fwd_rs), 32'd0);
`endif

        // Random mix on a small register window.
        for (int i = 0; i < 300; i++) begin
            id_t r;
            r.valid  = ($urandom_range(0, 3) != 0);
            r.rs     = 5'($urandom_range(0, 3));
            r.rt     = 5'($urandom_range(0, 3));
            r.rd     = 5'($urandom_range(0, 3));
            r.use_rs = 1'($urandom_range(0, 1));
            r.use_rt = 1'($urandom_range(0, 1));
            r.we_rd  = 1'($urandom_range(0, 1));
            r.we_rt  = 1'($urandom_range(0, 1));
            r.load   = 1'($urandom_range(0, 1));
            cyc("rand", r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 31) == 0));
        end

        // Drive the stall counter into saturation with a self-dependent load.
        drain(3);
        for (int n = 0; n < 5000 && m_cnt != CNT_MAX; n++) begin
            cyc("sat_run", lw(3, 3), 1'b0, 1'b0, 1'b0);
        end
        check("sat_reached", 32'(stall_cnt), 32'(CNT_MAX));
        for (int i = 0; i < 8; i++) begin
            cyc("sat_hold", lw(3, 3), 1'b0, 1'b0, 1'b0);
        end
        check("sat_stays", 32'(stall_cnt), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, stall performance counter width.
REQ-003 SHALL have i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have i_id_valid  input  1  ID-stage instruction present.
REQ-006 SHALL have i_id_rs, i_id_rt  input  REG_W each  ID source indices.
REQ-007 SHALL have i_id_use_rs, i_id_use_rt  input  1 each  source actually read.
REQ-008 SHALL have i_id_we_rd, i_id_we_rt  input  1 each  destination-decoder write enables.
REQ-009 SHALL have i_id_rd  input  REG_W  rd field; i_id_load  input  1  instruction is LW.
REQ-010 SHALL have i_flush  input  1  branch/jump taken, squash ID; i_hold  input  1  external freeze.
REQ-011 SHALL have o_stall  output  1  hold PC and IF/ID, bubble into EX.
REQ-012 SHALL have o_fwd_rs, o_fwd_rt  output  2 each  operand source select.
REQ-013 SHALL have o_stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-014 SHALL resolve the ID destination as i_id_rd when i_id_we_rd, i_id_rt when i_id_we_rt, else none; both set treated as rd.
REQ-015 SHALL track three in-flight entries EX, MEM, WB, each {valid, dst, load}; entries with dst 0 SHALL be stored invalid.
REQ-016 On each cycle with i_hold low, entries SHALL shift EX->MEM->WB, and EX SHALL load the resolved ID entry, or a bubble when o_stall, i_flush or !i_id_valid.
REQ-017 With i_hold high, all entries and o_stall_cnt SHALL hold; o_stall SHALL still reflect combinational hazard state.
REQ-018 A source matches an entry when used, index nonzero, entry valid and dst equal.
REQ-019 o_stall SHALL assert combinationally when i_id_valid, !i_flush, and any source matches an EX entry with load=1.
REQ-020 Forward select per source, youngest match wins: 2'b01 EX, 2'b10 MEM, 2'b11 WB, 2'b00 none/regfile; 2'b00 while o_stall.
REQ-021 i_flush with a simultaneous hazard SHALL win: o_stall low, bubble into EX.
REQ-022 o_stall_cnt SHALL increment by 1 each non-held cycle with o_stall high, saturating at all-ones.
REQ-023 Latency: hazard decisions zero-cycle from ID inputs; entry movement one cycle.

Reset
REQ-024 While i_rst high at a clock edge, all entries SHALL become invalid and o_stall_cnt zero; i_rst SHALL override i_hold.
REQ-025 After reset o_stall=0, o_fwd_rs=o_fwd_rt=2'b00 until a valid entry exists.
REQ-026 Reset mid-stall SHALL drop the stall the cycle after reset is sampled.

Configuration
REQ-027 Macro HAZARD_FWD_EN: defined -> forwarding per REQ-019/020.
REQ-028 Undefined -> o_fwd_rs/o_fwd_rt tied 2'b00; o_stall SHALL assert on any source match in EX, MEM or WB regardless of load.

Structure
REQ-029 Package mips_pkg SHALL hold REG_W default, forward-select encodings FWD_NONE/FWD_EX/FWD_MEM/FWD_WB, and the entry struct type.
REQ-030 One sub-module hazard_cmp SHALL compare one source against three entries, returning match vector; instantiated twice (rs, rt).

Verification
REQ-031 LW $t0 into EX, ID ADD reading rs=$t0 -> o_stall=1 one cycle, bubble in EX, next cycle o_fwd_rs=2'b10.
REQ-032 ADD writing $5 in EX and SUB writing $5 in MEM, ID reads rt=5 -> o_fwd_rt=2'b01, o_stall=0.
REQ-033 Writer of $0 in EX, ID reads rs=0 -> o_fwd_rs=2'b00, o_stall=0.
REQ-034 Load-use hazard with i_flush=1 same cycle -> o_stall=0, EX entry invalid next cycle.
REQ-035 i_hold=1 for 3 cycles during load-use -> entries frozen, o_stall_cnt unchanged; after release counts 1.
REQ-036 Without HAZARD_FWD_EN, ADD writing $3 in WB, ID reads $3 -> o_stall=1, o_fwd_rs=2'b00; counter at 2^16-1 stays saturated.
